alu_seq_multiplier: RTL and testbench



---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_seq_multiplier.sv | 129 ++++++++++++
 tb/tb_alu_seq_multiplier.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 32-bit ALU datapath blocks.
//   mul_state_t : control states of the sequential shift-add multiplier
//   ALU_WIDTH   : native operand width of the ALU datapath
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu_seq_multiplier.sv
// -----------------------------------------------------------------------------
// alu_seq_multiplier
// Multi-cycle shift-add multiplier producing a 2*WIDTH-bit product, one
// multiplier bit per clock. Signed operands are handled by multiplying the
// magnitudes and negating the final product when the operand signs differ.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous, active-high reset
//   start      in   request a multiply (sampled only in IDLE)
//   is_signed  in   1 = two's-complement operands, 0 = unsigned
//   A          in   multiplicand [WIDTH-1:0]
//   B          in   multiplier   [WIDTH-1:0]
//   busy       out  high while iterating
//   done       out  one-cycle pulse when prod_hi/prod_lo hold a new product
//   prod_hi    out  upper half of product [WIDTH-1:0]
//   prod_lo    out  lower half of product [WIDTH-1:0]
// -----------------------------------------------------------------------------
module alu_seq_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // Magnitude of an operand; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still
    // fits as an unsigned WIDTH-bit value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        if (sgn && v[WIDTH-1])
            return ~v + WIDTH'(1);
        else
            return v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate2w(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    mul_state_t         r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mult;
    logic [CNT_W-1:0]   r_count;
    logic               r_neg;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_prod_hi;
    logic [WIDTH-1:0]   r_prod_lo;

    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_product;
    logic [2*WIDTH-1:0] w_result;

    // Partial-product add into the upper accumulator half; bit WIDTH is the carry
    // that becomes the top bit after the right shift.
    assign w_sum     = {1'b0, r_acc} + {1'b0, (r_mult[0] ? r_mcand : '0)};
    assign w_product = {r_acc, r_mult};
    assign w_result  = r_neg ? negate2w(w_product) : w_product;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_mult    <= '0;
            r_count   <= '0;
            r_neg     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_prod_hi <= '0;
            r_prod_lo <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= BUSY;
                        r_busy  <= 1'b1;
                        r_mcand <= magnitude(A, is_signed);
                        r_mult  <= magnitude(B, is_signed);
                        r_neg   <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_acc   <= '0;
                        r_count <= '0;
                    end
                end
                BUSY: begin
                    // {carry, acc, mult} >> 1: consumed multiplier bits fall off
                    // the bottom while product bits fill r_mult from the top.
                    r_acc   <= w_sum[WIDTH:1];
                    r_mult  <= {w_sum[0], r_mult[WIDTH-1:1]};
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == CNT_W'(WIDTH - 1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                    end
                end
                DONE: begin
                    r_prod_hi <= w_result[2*WIDTH-1:WIDTH];
                    r_prod_lo <= w_result[WIDTH-1:0];
                    r_done    <= 1'b1;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign prod_hi = r_prod_hi;
    assign prod_lo = r_prod_lo;

endmodule

// File: tb/tb_alu_seq_multiplier.sv
module tb_alu_seq_multiplier;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic         is_signed;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] prod_hi;
    logic [W-1:0] prod_lo;

    alu_seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .prod_hi   (prod_hi),
        .prod_lo   (prod_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           edge_at;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    // Monitor: every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && done) begin
            check("busy_with_done", {63'd0, busy}, 64'd0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got product 0x%0h_%0h with nothing outstanding",
                         prod_hi, prod_lo);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("product", {prod_hi, prod_lo}, {e.hi, e.lo});
                check("done_latency", 64'(edge_cnt), 64'(e.edge_at));
            end
        end
    end

    // Start is sampled at the next rising edge; done is visible 33 edges later.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] hi, input logic [W-1:0] lo, input bit expect_it);
        exp_t e;
        @(negedge clk);
        A = a; B = b; is_signed = s; start = 1'b1;
        if (expect_it) begin
            e.hi = hi; e.lo = lo; e.edge_at = edge_cnt + 1 + W + 1;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", q.size());
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int busy_cycles;
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_prod", {prod_hi, prod_lo}, 64'd0);

        // 7 x 6 unsigned, also count busy cycles
        @(negedge clk);
        A = 32'd7; B = 32'd6; is_signed = 1'b0; start = 1'b1;
        begin
            exp_t e;
            e.hi = 32'h0; e.lo = 32'h2A; e.edge_at = edge_cnt + 1 + W + 1;
            q.push_back(e);
        end
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cycles++;
        end
        check("busy_cycles", 64'(busy_cycles), 64'd32);
        drain();

        launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 1'b1);
        drain();
        launch(32'hFFFFFFFD, 32'd5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1);
        drain();
        launch(32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000, 1'b1);
        drain();
        launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001, 1'b1);
        drain();
        launch(32'h80000000, 32'd2, 1'b0, 32'h00000001, 32'h00000000, 1'b1);
        drain();
        launch(32'd0, 32'hDEADBEEF, 1'b1, 32'h0, 32'h0, 1'b1);
        drain();

        // start during busy is ignored
        launch(32'd2, 32'd3, 1'b0, 32'h0, 32'd6, 1'b1);
        repeat (7) @(negedge clk);
        A = 32'd9; B = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (10) @(negedge clk);
        check("hold_after_ignored_start", {prod_hi, prod_lo}, 64'd6);

        // reset mid-operation
        launch(32'd5, 32'd5, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_prod", {prod_hi, prod_lo}, 64'd0);
        repeat (40) @(negedge clk);
        check("abort_prod_hold", {prod_hi, prod_lo}, 64'd0);
        launch(32'd4, 32'd4, 1'b0, 32'h0, 32'd16, 1'b1);
        drain();

        // back-to-back with start held high
        @(negedge clk);
        A = 32'd2; B = 32'd3; is_signed = 1'b0; start = 1'b1;
        begin
            exp_t e;
            e.hi = 32'h0; e.lo = 32'd6; e.edge_at = edge_cnt + 1 + W + 1;
            q.push_back(e);
            e.edge_at = edge_cnt + 1 + 2 * (W + 2) - 1;
            q.push_back(e);
        end
        repeat (W + 2) @(negedge clk);
        check("gap_busy", {63'd0, busy}, 64'd0);
        repeat (W + 2) @(negedge clk);
        start = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
